// File: rtl/hdmi_pkg.sv
// hdmi_pkg: TMDS control tokens, default 640x480@60 raster timing and the
// running-disparity width shared by the HDMI transmitter files.
package hdmi_pkg;

  // Control-period symbols indexed by C = {C1, C0}
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Default 640x480@60 timing (800 x 525 total)
  localparam int DEF_H_MAX       = 800;
  localparam int DEF_H_SYNC_MIN  = 16;
  localparam int DEF_H_SYNC_MAX  = 112;
  localparam int DEF_H_VALID_MIN = 160;
  localparam int DEF_V_MAX       = 525;
  localparam int DEF_V_SYNC_MIN  = 10;
  localparam int DEF_V_SYNC_MAX  = 12;
  localparam int DEF_V_VALID_MIN = 45;

  // Signed running disparity width per channel
  localparam int DISP_W = 5;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// tmds_encoder: one DVI 1.0 TMDS channel. Transition-minimising stage picks
// XOR/XNOR chaining, DC-balance stage tracks a signed running disparity.
// Control tokens are sent (and disparity cleared) while de is low.
// Output symbol is registered: one clock of latency.
module tmds_encoder
  import hdmi_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic [1:0] c,
  input  logic       de,
  output logic [9:0] q
);

  localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);

  logic [8:0]              q_m;
  logic [3:0]              n1_d;
  logic [3:0]              n1_q;
  logic                    use_xnor;
  logic signed [DISP_W-1:0] bal;       // ones minus zeros of q_m[7:0]
  logic signed [DISP_W-1:0] cnt_reg;
  logic signed [DISP_W-1:0] cnt_next;
  logic [9:0]              q_next;

  // Stage 1: chain the data bits with XOR or XNOR, whichever gives fewer transitions
  always_comb begin
    logic [8:0] t;
    n1_d     = ones8(d);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
    t        = '0;
    t[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      t[i] = use_xnor ? ~(t[i-1] ^ d[i]) : (t[i-1] ^ d[i]);
    end
    t[8] = ~use_xnor;
    q_m  = t;
  end

  // Stage 2: DC balance against the running disparity, or control token in blanking
  always_comb begin
    n1_q     = ones8(q_m[7:0]);
    // 2*n1 - 8, modular in DISP_W bits (the true range -8..8 always fits)
    bal      = $signed({n1_q, 1'b0}) - DISP_W'(8);
    q_next   = CTRL_00;
    cnt_next = cnt_reg;
    if (!de) begin
      q_next   = ctrl_token(c);
      cnt_next = '0;
    end else if ((cnt_reg == '0) || (bal == '0)) begin
      q_next   = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      cnt_next = q_m[8] ? (cnt_reg + bal) : (cnt_reg - bal);
    end else if (cnt_reg[DISP_W-1] == bal[DISP_W-1]) begin
      // Disparity and this word lean the same way: send the word inverted
      q_next   = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt_reg + (q_m[8] ? TWO : '0) - bal;
    end else begin
      q_next   = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt_reg - (q_m[8] ? '0 : TWO) + bal;
    end
  end

  // Register the symbol and the running disparity
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      q       <= CTRL_00;
      cnt_reg <= '0;
    end else begin
      q       <= q_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/hdmi_tx.sv
// hdmi_tx: raster timing generator plus three TMDS encoders for a DVI/HDMI
// output. h_pos/v_pos are combinational from the counters; hsync/vsync/de and
// tmds_* are registered one clock later.
// Build option HDMI_TEST_PATTERN_EN: ignore data and feed an internal pattern
// R=h_pos, G=v_pos, B=h_pos^v_pos (low 8 bits).
module hdmi_tx
  import hdmi_pkg::*;
#(
  parameter int H_MAX       = DEF_H_MAX,
  parameter int H_SYNC_MIN  = DEF_H_SYNC_MIN,
  parameter int H_SYNC_MAX  = DEF_H_SYNC_MAX,
  parameter int H_VALID_MIN = DEF_H_VALID_MIN,
  parameter int V_MAX       = DEF_V_MAX,
  parameter int V_SYNC_MIN  = DEF_V_SYNC_MIN,
  parameter int V_SYNC_MAX  = DEF_V_SYNC_MAX,
  parameter int V_VALID_MIN = DEF_V_VALID_MIN
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic [23:0] data,
  output logic [11:0] h_pos,
  output logic [11:0] v_pos,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [9:0]  tmds_b,
  output logic [9:0]  tmds_g,
  output logic [9:0]  tmds_r
);

  if (!(0 <= H_SYNC_MIN && H_SYNC_MIN < H_SYNC_MAX && H_SYNC_MAX <= H_VALID_MIN &&
        H_VALID_MIN < H_MAX && H_MAX <= 4095)) begin : g_bad_h_timing
    $fatal(1, "hdmi_tx: illegal horizontal timing parameters");
  end
  if (!(0 <= V_SYNC_MIN && V_SYNC_MIN < V_SYNC_MAX && V_SYNC_MAX <= V_VALID_MIN &&
        V_VALID_MIN < V_MAX && V_MAX <= 4095)) begin : g_bad_v_timing
    $fatal(1, "hdmi_tx: illegal vertical timing parameters");
  end

  localparam logic [11:0] H_MAX_C    = 12'(H_MAX);
  localparam logic [11:0] H_SMIN_C   = 12'(H_SYNC_MIN);
  localparam logic [11:0] H_SMAX_C   = 12'(H_SYNC_MAX);
  localparam logic [11:0] H_VALID_C  = 12'(H_VALID_MIN);
  localparam logic [11:0] V_MAX_C    = 12'(V_MAX);
  localparam logic [11:0] V_SMIN_C   = 12'(V_SYNC_MIN);
  localparam logic [11:0] V_SMAX_C   = 12'(V_SYNC_MAX);
  localparam logic [11:0] V_VALID_C  = 12'(V_VALID_MIN);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_valid, v_valid, h_sync, v_sync, de_c;
  logic [23:0] pix;

  // Raster counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX_C - 12'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX_C - 12'd1) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign h_valid = (h_cnt >= H_VALID_C) && (h_cnt < H_MAX_C);
  assign v_valid = (v_cnt >= V_VALID_C) && (v_cnt < V_MAX_C);
  assign h_sync  = (h_cnt >= H_SMIN_C) && (h_cnt < H_SMAX_C);
  assign v_sync  = (v_cnt >= V_SMIN_C) && (v_cnt < V_SMAX_C);
  assign de_c    = h_valid && v_valid;
  assign h_pos   = h_valid ? (h_cnt - H_VALID_C) : 12'd0;
  assign v_pos   = v_valid ? (v_cnt - V_VALID_C) : 12'd0;

`ifdef HDMI_TEST_PATTERN_EN
  logic unused_data;
  assign unused_data = ^data;
  assign pix = {h_pos[7:0], v_pos[7:0], h_pos[7:0] ^ v_pos[7:0]};
`else
  assign pix = data;
`endif

  // Sync/enable delayed one clock to line up with the encoder output
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      de    <= 1'b0;
    end else begin
      hsync <= h_sync;
      vsync <= v_sync;
      de    <= de_c;
    end
  end

  // Channel 0 = blue (carries syncs), 1 = green, 2 = red
  logic [7:0] chan_d [3];
  logic [1:0] chan_c [3];
  logic [9:0] chan_q [3];

  assign chan_d[0] = pix[7:0];
  assign chan_d[1] = pix[15:8];
  assign chan_d[2] = pix[23:16];
  assign chan_c[0] = {v_sync, h_sync};
  assign chan_c[1] = 2'b00;
  assign chan_c[2] = 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      tmds_encoder u_enc (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .d       (chan_d[gi]),
        .c       (chan_c[gi]),
        .de      (de_c),
        .q       (chan_q[gi])
      );
    end
  endgenerate

  assign tmds_b = chan_q[0];
  assign tmds_g = chan_q[1];
  assign tmds_r = chan_q[2];

endmodule

// File: tb/tb_hdmi_tx.sv
// tb_hdmi_tx: directed bench for hdmi_tx on a reduced raster (64 x 24) so that
// whole frames fit in a short run. Keeps its own raster model, decodes TMDS
// back to 8-bit pixels and checks sync/enable/token timing every cycle.
module tb_hdmi_tx;

  localparam int HM  = 64;
  localparam int HS0 = 4;
  localparam int HS1 = 10;
  localparam int HV  = 16;
  localparam int VM  = 24;
  localparam int VS0 = 2;
  localparam int VS1 = 4;
  localparam int VV  = 6;
  localparam int AW  = HM - HV;   // 48 active columns
  localparam int AH  = VM - VV;   // 18 active rows

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic [23:0] data;
  logic [11:0] h_pos, v_pos;
  logic        hsync, vsync, de;
  logic [9:0]  tmds_b, tmds_g, tmds_r;

  int tests_run    = 0;
  int tests_failed = 0;

  int mh, mv, mode;
  int disp [3];

  hdmi_tx #(
    .H_MAX(HM), .H_SYNC_MIN(HS0), .H_SYNC_MAX(HS1), .H_VALID_MIN(HV),
    .V_MAX(VM), .V_SYNC_MIN(VS0), .V_SYNC_MAX(VS1), .V_VALID_MIN(VV)
  ) dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .data    (data),
    .h_pos   (h_pos),
    .v_pos   (v_pos),
    .hsync   (hsync),
    .vsync   (vsync),
    .de      (de),
    .tmds_b  (tmds_b),
    .tmds_g  (tmds_g),
    .tmds_r  (tmds_r)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return TOK00;
      2'b01:   return TOK01;
      2'b10:   return TOK10;
      default: return TOK11;
    endcase
  endfunction

  function automatic int hpos_of(input int h);
    return (h >= HV) ? h - HV : 0;
  endfunction

  function automatic int vpos_of(input int v);
    return (v >= VV) ? v - VV : 0;
  endfunction

  // Pixel presented for raster position (h,v)
  function automatic logic [23:0] pix_of(input int h, input int v);
    logic [7:0] hb, vb;
    hb = 8'(hpos_of(h));
    vb = 8'(vpos_of(v));
`ifdef HDMI_TEST_PATTERN_EN
    return {hb, vb, hb ^ vb};
`else
    if (mode == 0) return 24'(hpos_of(h) + vpos_of(v) * AW);
    else           return {~hb, vb ^ 8'h5A, hb + vb} ^ 24'hA53C96;
`endif
  endfunction

  // Inverse of both encoder stages
  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] d, o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic int bal10(input logic [9:0] q);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(q[i]);
    return 2 * n - 10;
  endfunction

  // One clock: advance the model, then check the outputs produced by the previous position
  task automatic step();
    int ph, pv;
    bit phs, pvs, pde;
    logic [23:0] px;
    logic [9:0] sym [3];
    ph = mh;
    pv = mv;
    @(posedge clk_pix);
    #1;
    mh++;
    if (mh == HM) begin
      mh = 0;
      mv = (mv == VM - 1) ? 0 : mv + 1;
    end
    data = pix_of(mh, mv);
    phs = (ph >= HS0) && (ph < HS1);
    pvs = (pv >= VS0) && (pv < VS1);
    pde = (ph >= HV) && (pv >= VV);
    check("hsync", 32'(hsync), 32'(phs));
    check("vsync", 32'(vsync), 32'(pvs));
    check("de", 32'(de), 32'(pde));
    check("h_pos", 32'(h_pos), 32'(hpos_of(mh)));
    check("v_pos", 32'(v_pos), 32'(vpos_of(mv)));
    sym[0] = tmds_b;
    sym[1] = tmds_g;
    sym[2] = tmds_r;
    if (pde) begin
      px = pix_of(ph, pv);
      check("dec_b", 32'(tmds_dec(tmds_b)), 32'(px[7:0]));
      check("dec_g", 32'(tmds_dec(tmds_g)), 32'(px[15:8]));
      check("dec_r", 32'(tmds_dec(tmds_r)), 32'(px[23:16]));
      for (int k = 0; k < 3; k++) begin
        disp[k] += bal10(sym[k]);
        check("disp_bound", 32'(disp[k] <= 16 && disp[k] >= -16), 32'd1);
      end
    end else begin
      check("tok_b", 32'(tmds_b), 32'(tok({pvs, phs})));
      check("tok_g", 32'(tmds_g), 32'(TOK00));
      check("tok_r", 32'(tmds_r), 32'(TOK00));
      for (int k = 0; k < 3; k++) disp[k] = 0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tmds_b"}, 32'(tmds_b), 32'(TOK00));
    check({tag, "_tmds_g"}, 32'(tmds_g), 32'(TOK00));
    check({tag, "_tmds_r"}, 32'(tmds_r), 32'(TOK00));
    check({tag, "_hsync"}, 32'(hsync), 32'd0);
    check({tag, "_vsync"}, 32'(vsync), 32'd0);
    check({tag, "_de"}, 32'(de), 32'd0);
    check({tag, "_h_pos"}, 32'(h_pos), 32'd0);
    check({tag, "_v_pos"}, 32'(v_pos), 32'd0);
  endtask

  initial begin
    int de_cnt, vs_cnt, hs_cnt, vmax, hmax, n;
    rst_n = 1'b0;
    mode  = 0;
    mh    = 0;
    mv    = 0;
    for (int k = 0; k < 3; k++) disp[k] = 0;
    data  = 24'h0;
    repeat (3) @(posedge clk_pix);
    #1;
    check_reset_state("rst");

    data = pix_of(0, 0);
    @(negedge clk_pix);
    rst_n = 1'b1;

    // First full frame with frame-level statistics
    de_cnt = 0; vs_cnt = 0; hs_cnt = 0; vmax = 0; hmax = 0;
    for (int i = 0; i < HM * VM; i++) begin
      step();
      if (de)    de_cnt++;
      if (vsync) vs_cnt++;
      if (hsync) hs_cnt++;
      if (int'(v_pos) > vmax) vmax = int'(v_pos);
      if (int'(h_pos) > hmax) hmax = int'(h_pos);
    end
    check("frame_de_cycles", 32'(de_cnt), 32'd864);      // 48 * 18
    check("frame_vsync_cycles", 32'(vs_cnt), 32'd128);   // lines 2..3 x 64
    check("frame_hsync_cycles", 32'(hs_cnt), 32'd144);   // 6 per line x 24
    check("frame_v_pos_max", 32'(vmax), 32'(AH - 1));
    check("frame_h_pos_max", 32'(hmax), 32'(AW - 1));
    check("frame_wrap_h", 32'(mh), 32'd0);
    check("frame_wrap_v", 32'(mv), 32'd0);

    // Run into the active area, then reset asynchronously mid-frame
    n = 0;
    while (!(mh == 30 && mv == 10) && n < 2000) begin
      step();
      n++;
    end
    check("reach_mid_frame", 32'(mh == 30 && mv == 10), 32'd1);
    check("mid_de_before_reset", 32'(h_pos), 32'(30 - HV));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (2) @(posedge clk_pix);
    #1;
    check_reset_state("midrst_hold");

    // Second run with a different pixel pattern
    mode = 1;
    mh   = 0;
    mv   = 0;
    for (int k = 0; k < 3; k++) disp[k] = 0;
    data = pix_of(0, 0);
    @(negedge clk_pix);
    rst_n = 1'b1;
    for (int i = 0; i < HM * VM + 64; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
